pipeline_perf_scoreboard: RTL and testbench

- Synthesizable end-of-test monitor for the pipelined RV32I core with branch prediction.
- Sits in the bench beside the core and watches the core's debug and peripheral outputs. It never drives the core.
- Counts cycles, retired instructions, control-transfer instructions and mispredictions.
- Detects program halt (a self-loop at a single PC) or timeout, then compares red LEDs against an expected value to give a pass/fail verdict.

---
 rtl/pipeline_perf_scoreboard_if.sv | 51 +++++
 rtl/pipeline_perf_scoreboard.sv | 200 ++++++++++++++++++++
 tb/tb_pipeline_perf_scoreboard.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_perf_scoreboard_if.sv
// ---------------------------------------------------------------------------
// pipeline_perf_scoreboard_if
//
// Purpose: groups everything the RV32I core exposes to the end-of-test
// scoreboard: peripheral outputs (switches, LCD, LEDs, seven-segment) and
// the retirement debug stream (valid, PC, control-transfer, mispredict).
//
// Modports:
//   master - the core side; drives every signal.
//   slave  - the observer side (the scoreboard); reads every signal.
//
// Signals:
//   io_sw, io_lcd, io_ledr, io_ledg  32-bit peripheral values
//   io_hex0 .. io_hex7               7-bit seven-segment digits
//   insn_vld                         an instruction retires this cycle
//   pc_debug                         PC of the retiring instruction
//   ctrl                             retiring instruction is a branch/jump
//   mispred                          retiring control insn was mispredicted
// ---------------------------------------------------------------------------
interface pipeline_perf_scoreboard_if;
    logic [31:0] io_sw;
    logic [31:0] io_lcd;
    logic [31:0] io_ledr;
    logic [31:0] io_ledg;
    logic [6:0]  io_hex0;
    logic [6:0]  io_hex1;
    logic [6:0]  io_hex2;
    logic [6:0]  io_hex3;
    logic [6:0]  io_hex4;
    logic [6:0]  io_hex5;
    logic [6:0]  io_hex6;
    logic [6:0]  io_hex7;
    logic        insn_vld;
    logic [31:0] pc_debug;
    logic        ctrl;
    logic        mispred;

    modport master (
        output io_sw, io_lcd, io_ledr, io_ledg,
        output io_hex0, io_hex1, io_hex2, io_hex3,
        output io_hex4, io_hex5, io_hex6, io_hex7,
        output insn_vld, pc_debug, ctrl, mispred
    );

    modport slave (
        input io_sw, io_lcd, io_ledr, io_ledg,
        input io_hex0, io_hex1, io_hex2, io_hex3,
        input io_hex4, io_hex5, io_hex6, io_hex7,
        input insn_vld, pc_debug, ctrl, mispred
    );
endinterface

// File: rtl/pipeline_perf_scoreboard.sv
// ---------------------------------------------------------------------------
// pipeline_perf_scoreboard
//
// Purpose: passive end-of-test monitor for the pipelined RV32I core. Counts
// cycles, retirements, control-transfer retirements and mispredictions,
// detects program halt (the same PC retiring HALT_REPEAT more times in a
// row) or a cycle-budget timeout, and latches a pass/fail verdict based on
// the red LEDs at halt. Never drives the core.
//
// Ports:
//   i_clk, i_reset    clock (rising edge), synchronous active-high reset
//   mon               observer (slave) view of the core's outputs
//   o_done            sticky: test finished by halt or timeout
//   o_pass            verdict, meaningful while o_done is high
//   o_timeout         sticky: finished by timeout
//   o_proto_err       sticky: mispredict flagged on a non-control retirement
//   o_cycle_cnt       cycles since reset (saturating)
//   o_insn_cnt        valid retirements (saturating)
//   o_ctrl_cnt        valid control-transfer retirements (saturating)
//   o_mispred_cnt     valid mispredicted retirements (saturating)
//   o_halt_pc         PC at which halt was detected
//
// Optional feature: define SCOREBOARD_REPORT_EN to compile a simulation-only
// summary print plus $finish on the edge where o_done rises. Hardware
// behaviour is the same with or without it.
// ---------------------------------------------------------------------------
module pipeline_perf_scoreboard #(
    parameter int          CNT_W       = 32,
    parameter int          HALT_REPEAT = 4,
    parameter int          TIMEOUT_CYC = 50000,
    parameter logic [31:0] EXP_LEDR    = 32'h0000_0000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    pipeline_perf_scoreboard_if.slave mon,
    output logic                    o_done,
    output logic                    o_pass,
    output logic                    o_timeout,
    output logic                    o_proto_err,
    output logic [CNT_W-1:0]        o_cycle_cnt,
    output logic [CNT_W-1:0]        o_insn_cnt,
    output logic [CNT_W-1:0]        o_ctrl_cnt,
    output logic [CNT_W-1:0]        o_mispred_cnt,
    output logic [31:0]             o_halt_pc
);

    localparam int               REP_W     = $clog2(HALT_REPEAT + 1);
    localparam logic [REP_W-1:0] REP_MAX   = REP_W'(HALT_REPEAT);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [REP_W-1:0] REP_ONE   = {{(REP_W-1){1'b0}}, 1'b1};

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Repeat counter stops at HALT_REPEAT.
    function automatic logic [REP_W-1:0] rep_sat_inc(input logic [REP_W-1:0] v);
        return (v == REP_MAX) ? v : v + REP_ONE;
    endfunction

    logic [31:0]      last_pc;
    logic             last_vld;
    logic [REP_W-1:0] rep_cnt;

    logic [31:0]      last_pc_nxt;
    logic             last_vld_nxt;
    logic [REP_W-1:0] rep_nxt;
    logic             done_nxt;
    logic             pass_nxt;
    logic             timeout_nxt;
    logic             proto_nxt;
    logic [CNT_W-1:0] cycle_nxt;
    logic [CNT_W-1:0] insn_nxt;
    logic [CNT_W-1:0] ctrl_nxt;
    logic [CNT_W-1:0] mispred_nxt;
    logic [31:0]      halt_pc_nxt;
    logic             pc_same;
    logic             halt_hit;
    logic             timeout_hit;

    // Switches, LCD, green LEDs and hex digits are observed but never checked.
    logic unused_mon;
    assign unused_mon = ^{mon.io_sw, mon.io_lcd, mon.io_ledg,
                          mon.io_hex0, mon.io_hex1, mon.io_hex2, mon.io_hex3,
                          mon.io_hex4, mon.io_hex5, mon.io_hex6, mon.io_hex7};

    always_comb begin
        last_pc_nxt  = last_pc;
        last_vld_nxt = last_vld;
        rep_nxt      = rep_cnt;
        done_nxt     = o_done;
        pass_nxt     = o_pass;
        timeout_nxt  = o_timeout;
        proto_nxt    = o_proto_err;
        cycle_nxt    = o_cycle_cnt;
        insn_nxt     = o_insn_cnt;
        ctrl_nxt     = o_ctrl_cnt;
        mispred_nxt  = o_mispred_cnt;
        halt_pc_nxt  = o_halt_pc;
        halt_hit     = 1'b0;
        timeout_hit  = 1'b0;
        pc_same      = last_vld && (mon.pc_debug == last_pc);

        // Everything freezes once done; only reset can restart the monitor.
        if (!o_done) begin
            cycle_nxt = sat_inc(o_cycle_cnt);

            if (mon.insn_vld) begin
                insn_nxt = sat_inc(o_insn_cnt);
                if (mon.ctrl) begin
                    ctrl_nxt = sat_inc(o_ctrl_cnt);
                end
                // A mispredict on a non-control retirement still counts,
                // but it means the core's debug stream is inconsistent.
                if (mon.mispred) begin
                    mispred_nxt = sat_inc(o_mispred_cnt);
                end
                if (mon.mispred && !mon.ctrl) begin
                    proto_nxt = 1'b1;
                end

                // Idle cycles leave last_pc/rep_cnt alone, so bubbles
                // between retirements of a self-loop do not break the chain.
                rep_nxt      = pc_same ? rep_sat_inc(rep_cnt) : '0;
                last_pc_nxt  = mon.pc_debug;
                last_vld_nxt = 1'b1;
                halt_hit     = pc_same && (rep_nxt == REP_MAX);
            end

            timeout_hit = (cycle_nxt == TIMEOUT_V);

            // Halt takes priority over a timeout landing on the same edge.
            if (halt_hit) begin
                done_nxt    = 1'b1;
                halt_pc_nxt = mon.pc_debug;
                pass_nxt    = (mon.io_ledr == EXP_LEDR) && !proto_nxt;
            end else if (timeout_hit) begin
                done_nxt    = 1'b1;
                timeout_nxt = 1'b1;
                pass_nxt    = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            last_pc       <= '0;
            last_vld      <= 1'b0;
            rep_cnt       <= '0;
            o_done        <= 1'b0;
            o_pass        <= 1'b0;
            o_timeout     <= 1'b0;
            o_proto_err   <= 1'b0;
            o_cycle_cnt   <= '0;
            o_insn_cnt    <= '0;
            o_ctrl_cnt    <= '0;
            o_mispred_cnt <= '0;
            o_halt_pc     <= '0;
        end else begin
            last_pc       <= last_pc_nxt;
            last_vld      <= last_vld_nxt;
            rep_cnt       <= rep_nxt;
            o_done        <= done_nxt;
            o_pass        <= pass_nxt;
            o_timeout     <= timeout_nxt;
            o_proto_err   <= proto_nxt;
            o_cycle_cnt   <= cycle_nxt;
            o_insn_cnt    <= insn_nxt;
            o_ctrl_cnt    <= ctrl_nxt;
            o_mispred_cnt <= mispred_nxt;
            o_halt_pc     <= halt_pc_nxt;
        end
    end

`ifdef SCOREBOARD_REPORT_EN
    // Prints the values being registered on the edge where o_done rises.
    always @(posedge i_clk) begin
        if (!i_reset && !o_done && done_nxt) begin
            if (halt_hit && pass_nxt)
                $display("[scoreboard] result: PASS");
            else if (timeout_nxt)
                $display("[scoreboard] result: TIMEOUT");
            else
                $display("[scoreboard] result: FAIL");
            $display("[scoreboard] cycles=%0d insns=%0d ctrl=%0d mispred=%0d",
                     cycle_nxt, insn_nxt, ctrl_nxt, mispred_nxt);
            if (ctrl_nxt == '0)
                $display("[scoreboard] mispredict rate: n/a");
            else
                $display("[scoreboard] mispredict rate: %0d%%",
                         (64'(mispred_nxt) * 64'd100) / 64'(ctrl_nxt));
            $display("[scoreboard] halt pc: 0x%08h", halt_pc_nxt);
            $finish;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_perf_scoreboard.sv
module tb_pipeline_perf_scoreboard;

    localparam logic [31:0] EXP_LEDR = 32'h0000_0000;

    typedef struct packed {
        logic        done;
        logic        pass;
        logic        timeout;
        logic        proto;
        logic [31:0] halt_pc;
        logic [31:0] cycle;
        logic [31:0] insn;
        logic [31:0] ctrl;
        logic [31:0] mispred;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_perf_scoreboard_if bus();

    // Default-parameter instance
    logic        a_done, a_pass, a_timeout, a_proto;
    logic [31:0] a_cycle, a_insn, a_ctrl, a_mispred, a_halt_pc;
    // Short-timeout instance, same stimulus
    logic        t_done, t_pass, t_timeout, t_proto;
    logic [31:0] t_cycle, t_insn, t_ctrl, t_mispred, t_halt_pc;

    pipeline_perf_scoreboard dut (
        .i_clk(clk), .i_reset(rst), .mon(bus),
        .o_done(a_done), .o_pass(a_pass), .o_timeout(a_timeout),
        .o_proto_err(a_proto), .o_cycle_cnt(a_cycle), .o_insn_cnt(a_insn),
        .o_ctrl_cnt(a_ctrl), .o_mispred_cnt(a_mispred), .o_halt_pc(a_halt_pc)
    );

    pipeline_perf_scoreboard #(.TIMEOUT_CYC(20)) dut_to (
        .i_clk(clk), .i_reset(rst), .mon(bus),
        .o_done(t_done), .o_pass(t_pass), .o_timeout(t_timeout),
        .o_proto_err(t_proto), .o_cycle_cnt(t_cycle), .o_insn_cnt(t_insn),
        .o_ctrl_cnt(t_ctrl), .o_mispred_cnt(t_mispred), .o_halt_pc(t_halt_pc)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic res_t mk(input logic d, input logic p, input logic t, input logic pe,
                                input logic [31:0] hpc, input logic [31:0] cyc,
                                input logic [31:0] ins, input logic [31:0] ct,
                                input logic [31:0] mp);
        res_t r;
        r.done = d; r.pass = p; r.timeout = t; r.proto = pe;
        r.halt_pc = hpc; r.cycle = cyc; r.insn = ins; r.ctrl = ct; r.mispred = mp;
        return r;
    endfunction

    function automatic res_t snap(input bit sel);
        if (sel)
            return mk(t_done, t_pass, t_timeout, t_proto, t_halt_pc,
                      t_cycle, t_insn, t_ctrl, t_mispred);
        return mk(a_done, a_pass, a_timeout, a_proto, a_halt_pc,
                  a_cycle, a_insn, a_ctrl, a_mispred);
    endfunction

    task automatic cmp(input string tag, input res_t g, input res_t e);
        check({tag, ".done"},    32'(g.done),    32'(e.done));
        check({tag, ".pass"},    32'(g.pass),    32'(e.pass));
        check({tag, ".timeout"}, 32'(g.timeout), 32'(e.timeout));
        check({tag, ".proto"},   32'(g.proto),   32'(e.proto));
        check({tag, ".halt_pc"}, g.halt_pc, e.halt_pc);
        check({tag, ".cycle"},   g.cycle,   e.cycle);
        check({tag, ".insn"},    g.insn,    e.insn);
        check({tag, ".ctrl"},    g.ctrl,    e.ctrl);
        check({tag, ".mispred"}, g.mispred, e.mispred);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs(input logic [31:0] ledr);
        bus.insn_vld = 1'b0;
        bus.ctrl     = 1'b0;
        bus.mispred  = 1'b0;
        bus.pc_debug = 32'h0;
        bus.io_ledr  = ledr;
    endtask

    task automatic randomize_inputs();
        bus.io_sw    = $urandom;
        bus.io_lcd   = $urandom;
        bus.io_ledr  = $urandom;
        bus.io_ledg  = $urandom;
        bus.io_hex0  = 7'($urandom);
        bus.io_hex1  = 7'($urandom);
        bus.io_hex2  = 7'($urandom);
        bus.io_hex3  = 7'($urandom);
        bus.io_hex4  = 7'($urandom);
        bus.io_hex5  = 7'($urandom);
        bus.io_hex6  = 7'($urandom);
        bus.io_hex7  = 7'($urandom);
        bus.insn_vld = 1'($urandom);
        bus.ctrl     = 1'($urandom);
        bus.mispred  = 1'($urandom);
        bus.pc_debug = $urandom;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            randomize_inputs();
            tick();
        end
        rst = 1'b0;
        idle_inputs(EXP_LEDR);
    endtask

    // One retirement on the next edge; inputs return to idle afterwards.
    task automatic retire(input logic [31:0] pc, input logic c, input logic m);
        bus.insn_vld = 1'b1;
        bus.pc_debug = pc;
        bus.ctrl     = c;
        bus.mispred  = m;
        tick();
        bus.insn_vld = 1'b0;
        bus.ctrl     = 1'b0;
        bus.mispred  = 1'b0;
    endtask

    // Waits (bounded) for the selected instance to finish, then pops and
    // compares the oldest expected result.
    task automatic wait_done(input bit sel, input string tag);
        res_t e;
        int   n = 0;
        while (!snap(sel).done && n < 50) begin
            tick();
            n++;
        end
        if (exp_q.size() == 0) begin
            check({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            cmp(tag, snap(sel), e);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs, then idle counting.
        do_reset(3);
        cmp("reset_a", snap(0), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        cmp("reset_t", snap(1), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++) tick();
        cmp("idle", snap(0), mk(0, 0, 0, 0, 0, 10, 0, 0, 0));

        // Halt with matching LEDs.
        exp_q.push_back(mk(1, 1, 0, 0, 32'h8, 17, 7, 1, 1));
        retire(32'h0, 0, 0);
        retire(32'h4, 0, 0);
        retire(32'h8, 1, 1);
        for (int i = 0; i < 3; i++) retire(32'h8, 0, 0);
        check("pre_halt.done", 32'(a_done), 32'd0);
        retire(32'h8, 0, 0);
        wait_done(0, "halt_pass");
        retire(32'h20, 1, 1);
        tick();
        check("freeze.cycle", a_cycle, 32'd17);
        check("freeze.insn",  a_insn,  32'd7);
        check("freeze.ctrl",  a_ctrl,  32'd1);

        // Same sequence, LEDs mismatch.
        do_reset(2);
        bus.io_ledr = EXP_LEDR ^ 32'h1;
        exp_q.push_back(mk(1, 0, 0, 0, 32'h8, 7, 7, 1, 1));
        retire(32'h0, 0, 0);
        retire(32'h4, 0, 0);
        retire(32'h8, 1, 1);
        for (int i = 0; i < 4; i++) retire(32'h8, 0, 0);
        wait_done(0, "halt_ledfail");

        // Protocol error, bubble inside the repeat chain.
        do_reset(2);
        retire(32'h0, 0, 1);
        check("proto_set", 32'(a_proto), 32'd1);
        exp_q.push_back(mk(1, 0, 0, 1, 32'h10, 7, 6, 0, 1));
        retire(32'h10, 0, 0);
        retire(32'h10, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) retire(32'h10, 0, 0);
        wait_done(0, "halt_proto");

        // Timeout on the short-budget instance, PC always changing.
        do_reset(2);
        exp_q.push_back(mk(1, 0, 1, 0, 32'h0, 20, 20, 0, 0));
        for (int i = 0; i < 40; i++) begin
            if (t_done) break;
            retire(32'(i * 4), 0, 0);
        end
        wait_done(1, "timeout");
        for (int i = 0; i < 5; i++) retire(32'h100, 1, 0);
        check("to_freeze.cycle",   t_cycle,          32'd20);
        check("to_freeze.insn",    t_insn,           32'd20);
        check("to_freeze.ctrl",    t_ctrl,           32'd0);
        check("to_freeze.timeout", 32'(t_timeout),   32'd1);

        // Reset after done clears everything; counting restarts.
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp("rst_after_done", snap(1), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tick();
        check("restart.cycle", t_cycle,        32'd3);
        check("restart.done",  32'(t_done),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
